// File: rtl/periph_buf_pkg.sv
// Shared constants and helpers for the peripheral slave buffer.
package periph_buf_pkg;

   localparam logic PERIPH_OPC_OK  = 1'b0;
   localparam logic PERIPH_OPC_ERR = 1'b1;

   // Pointer and counter widths never collapse to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/periph_buf_fifo.sv
// Small synchronous FIFO with a registered occupancy count; head is the oldest entry.
module periph_buf_fifo
   import periph_buf_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned PTR_W = clog2_min1(DEPTH);
   localparam int unsigned CNT_W = clog2_min1(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is deliberately not reset; the occupancy count alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/periph_slave_buffer.sv
// Crossbar-slave to slow-peripheral buffer: request FIFO, in-order ID tracking, registered responses.
module periph_slave_buffer
   import periph_buf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = 9,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_req_i,
   input  logic [ADDR_WIDTH-1:0] s_add_i,
   input  logic                  s_wen_i,
   input  logic [DATA_WIDTH-1:0] s_wdata_i,
   input  logic [BE_WIDTH-1:0]   s_be_i,
   input  logic [ID_WIDTH-1:0]   s_id_i,
   output logic                  s_gnt_o,
   output logic                  s_r_valid_o,
   output logic [ID_WIDTH-1:0]   s_r_id_o,
   output logic                  s_r_opc_o,
   output logic [DATA_WIDTH-1:0] s_r_rdata_o,
   output logic                  m_req_o,
   output logic [ADDR_WIDTH-1:0] m_add_o,
   output logic                  m_wen_o,
   output logic [DATA_WIDTH-1:0] m_wdata_o,
   output logic [BE_WIDTH-1:0]   m_be_o,
   input  logic                  m_gnt_i,
   input  logic                  m_r_valid_i,
   input  logic                  m_r_opc_i,
   input  logic [DATA_WIDTH-1:0] m_r_rdata_i,
   output logic                  err_o
);

   localparam int unsigned CNT_W = clog2_min1(DEPTH + 1);
   localparam int unsigned PAY_W = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
   logic                  s_push, m_pop, resp_take, resp_spur;
   logic [PAY_W-1:0]      pay_head;
   logic [ID_WIDTH-1:0]   id_head;
   logic                  pay_empty, pay_full, id_empty, id_full;
   logic                  unused_fifo_flags;

   logic                  s_r_valid_q, s_r_valid_d;
   logic [ID_WIDTH-1:0]   s_r_id_q, s_r_id_d;
   logic                  s_r_opc_q, s_r_opc_d;
   logic [DATA_WIDTH-1:0] s_r_rdata_q, s_r_rdata_d;
   logic                  err_q, err_d;

   assign s_gnt_o   = (out_cnt_q < CNT_MAX) & ~rst_i;
   assign s_push    = s_req_i & s_gnt_o;
   assign resp_take = m_r_valid_i & (out_cnt_q != '0) & ~rst_i;
   assign resp_spur = m_r_valid_i & (out_cnt_q == '0) & ~rst_i;
   assign m_req_o   = ~pay_empty & ~rst_i;
   assign m_pop     = m_req_o & m_gnt_i;

   // out_cnt bounds both FIFOs, so their full flags are never needed.
   assign unused_fifo_flags = pay_full ^ id_full ^ id_empty;

   periph_buf_fifo #(.WIDTH(PAY_W), .DEPTH(DEPTH)) u_pay_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (s_push),
      .data_i  ({s_add_i, s_wen_i, s_wdata_i, s_be_i}),
      .pop_i   (m_pop),
      .full_o  (pay_full),
      .empty_o (pay_empty),
      .head_o  (pay_head)
   );

   periph_buf_fifo #(.WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (s_push),
      .data_i  (s_id_i),
      .pop_i   (resp_take),
      .full_o  (id_full),
      .empty_o (id_empty),
      .head_o  (id_head)
   );

   assign {m_add_o, m_wen_o, m_wdata_o, m_be_o} = rst_i ? '0 : pay_head;

   always_comb begin
      out_cnt_d   = out_cnt_q;
      s_r_valid_d = resp_take;
      s_r_id_d    = s_r_id_q;
      s_r_opc_d   = s_r_opc_q;
      s_r_rdata_d = s_r_rdata_q;
      err_d       = resp_spur;
      if (s_push && !resp_take)      out_cnt_d = out_cnt_q + CNT_W'(1);
      else if (!s_push && resp_take) out_cnt_d = out_cnt_q - CNT_W'(1);
      if (resp_take) begin
         s_r_id_d    = id_head;
         s_r_opc_d   = m_r_opc_i;
         s_r_rdata_d = m_r_rdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_cnt_q   <= '0;
         s_r_valid_q <= 1'b0;
         s_r_id_q    <= '0;
         s_r_opc_q   <= PERIPH_OPC_OK;
         s_r_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         out_cnt_q   <= out_cnt_d;
         s_r_valid_q <= s_r_valid_d;
         s_r_id_q    <= s_r_id_d;
         s_r_opc_q   <= s_r_opc_d;
         s_r_rdata_q <= s_r_rdata_d;
         err_q       <= err_d;
      end
   end

   // Registered outputs are also forced low during the reset cycle itself.
   assign s_r_valid_o = s_r_valid_q & ~rst_i;
   assign s_r_id_o    = rst_i ? '0 : s_r_id_q;
   assign s_r_opc_o   = s_r_opc_q & ~rst_i;
   assign s_r_rdata_o = rst_i ? '0 : s_r_rdata_q;
   assign err_o       = err_q & ~rst_i;

endmodule

// File: tb/tb_periph_slave_buffer.sv
// Self-checking bench: directed vector table plus ordering, spurious and reset sequences.
module tb_periph_slave_buffer;
   import periph_buf_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i, s_req_i, s_wen_i, m_gnt_i, m_r_valid_i, m_r_opc_i;
   logic [31:0] s_add_i, s_wdata_i, m_r_rdata_i;
   logic [3:0]  s_be_i;
   logic [8:0]  s_id_i;
   logic        s_gnt_o, s_r_valid_o, s_r_opc_o, m_req_o, m_wen_o, err_o;
   logic [8:0]  s_r_id_o;
   logic [31:0] s_r_rdata_o, m_add_o, m_wdata_o;
   logic [3:0]  m_be_o;

   int checks = 0;
   int errors = 0;

   periph_slave_buffer dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i), .s_wdata_i(s_wdata_i),
      .s_be_i(s_be_i), .s_id_i(s_id_i), .s_gnt_o(s_gnt_o),
      .s_r_valid_o(s_r_valid_o), .s_r_id_o(s_r_id_o), .s_r_opc_o(s_r_opc_o), .s_r_rdata_o(s_r_rdata_o),
      .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_wdata_o(m_wdata_o), .m_be_o(m_be_o),
      .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i), .m_r_opc_i(m_r_opc_i), .m_r_rdata_i(m_r_rdata_i),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, req;
      logic [31:0] add;
      logic [8:0]  id;
      logic        wen, gnt, rv, opc;
      logic [31:0] rdata;
      logic        e_gnt, e_mreq;
      logic [31:0] e_madd;
      logic        e_mwen, e_rv;
      logic [8:0]  e_rid;
      logic        e_ropc;
      logic [31:0] e_rdata;
      logic        e_err;
   } vec_t;

   function automatic vec_t mk(
      input logic rst, input logic req, input logic [31:0] add, input logic [8:0] id,
      input logic wen, input logic gnt, input logic rv, input logic opc, input logic [31:0] rdata,
      input logic e_gnt, input logic e_mreq, input logic [31:0] e_madd, input logic e_mwen,
      input logic e_rv, input logic [8:0] e_rid, input logic e_ropc, input logic [31:0] e_rdata,
      input logic e_err);
      vec_t v;
      v.rst = rst; v.req = req; v.add = add; v.id = id; v.wen = wen; v.gnt = gnt;
      v.rv = rv; v.opc = opc; v.rdata = rdata; v.e_gnt = e_gnt; v.e_mreq = e_mreq;
      v.e_madd = e_madd; v.e_mwen = e_mwen; v.e_rv = e_rv; v.e_rid = e_rid;
      v.e_ropc = e_ropc; v.e_rdata = e_rdata; v.e_err = e_err;
      return v;
   endfunction

   task automatic drive_req(input logic req, input logic [31:0] add, input logic [8:0] id, input logic wen);
      s_req_i   = req;
      s_add_i   = add;
      s_id_i    = id;
      s_wen_i   = wen;
      s_wdata_i = add ^ 32'h5A5A_5A5A;
      s_be_i    = add[5:2];
   endtask

   vec_t        vecs [17];
   logic [8:0]  ord_ids [4];
   int          due_q [$];
   logic [8:0]  exp_q [$];
   logic [31:0] exp_madd;

   initial begin
      rst_i = 1'b1; m_gnt_i = 1'b0; m_r_valid_i = 1'b0; m_r_opc_i = 1'b0; m_r_rdata_i = '0;
      drive_req(1'b0, '0, '0, 1'b0);
      repeat (2) @(posedge clk_i);

      //            rst req add           id     wen gnt rv opc rdata          gnt mreq madd         mwen rv rid    ropc rdata          err
      vecs[0]  = mk(1, 0, 32'h0,        9'h0,   0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 9'h0,   0, 32'h0,         0);
      vecs[1]  = mk(0, 1, 32'h1000_0004, 9'h004, 1, 1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 9'h0,   0, 32'h0,         0);
      vecs[2]  = mk(0, 0, 32'h0,        9'h0,   0, 1, 0, 0, 32'h0,         1, 1, 32'h1000_0004, 1, 0, 9'h0,   0, 32'h0,         0);
      vecs[3]  = mk(0, 0, 32'h0,        9'h0,   0, 1, 1, 0, 32'hDEAD_BEEF, 1, 0, 32'h0,         0, 0, 9'h0,   0, 32'h0,         0);
      vecs[4]  = mk(0, 0, 32'h0,        9'h0,   0, 1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 1, 9'h004, 0, 32'hDEAD_BEEF, 0);
      vecs[5]  = mk(0, 1, 32'h2000_0000, 9'h001, 0, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 9'h004, 0, 32'hDEAD_BEEF, 0);
      vecs[6]  = mk(0, 1, 32'h2000_0004, 9'h002, 0, 0, 0, 0, 32'h0,         1, 1, 32'h2000_0000, 0, 0, 9'h004, 0, 32'hDEAD_BEEF, 0);
      vecs[7]  = mk(0, 1, 32'h2000_0008, 9'h003, 0, 0, 0, 0, 32'h0,         0, 1, 32'h2000_0000, 0, 0, 9'h004, 0, 32'hDEAD_BEEF, 0);
      vecs[8]  = mk(0, 1, 32'h2000_0008, 9'h003, 0, 1, 0, 0, 32'h0,         0, 1, 32'h2000_0000, 0, 0, 9'h004, 0, 32'hDEAD_BEEF, 0);
      vecs[9]  = mk(0, 1, 32'h2000_0008, 9'h003, 0, 0, 1, 0, 32'h11,        0, 1, 32'h2000_0004, 0, 0, 9'h004, 0, 32'hDEAD_BEEF, 0);
      vecs[10] = mk(0, 1, 32'h2000_0008, 9'h003, 0, 0, 0, 0, 32'h0,         1, 1, 32'h2000_0004, 0, 1, 9'h001, 0, 32'h11,        0);
      vecs[11] = mk(0, 0, 32'h0,        9'h0,   0, 1, 0, 0, 32'h0,         0, 1, 32'h2000_0004, 0, 0, 9'h001, 0, 32'h11,        0);
      vecs[12] = mk(0, 0, 32'h0,        9'h0,   0, 1, 1, PERIPH_OPC_ERR, 32'hBAD0_0002, 0, 1, 32'h2000_0008, 0, 0, 9'h001, 0, 32'h11, 0);
      vecs[13] = mk(0, 0, 32'h0,        9'h0,   0, 0, 1, 0, 32'h33,        1, 0, 32'h0,         0, 1, 9'h002, 1, 32'hBAD0_0002, 0);
      vecs[14] = mk(0, 0, 32'h0,        9'h0,   0, 0, 1, 0, 32'h44,        1, 0, 32'h0,         0, 1, 9'h003, 0, 32'h33,        0);
      vecs[15] = mk(0, 0, 32'h0,        9'h0,   0, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 9'h003, 0, 32'h33,        1);
      vecs[16] = mk(0, 0, 32'h0,        9'h0,   0, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 9'h003, 0, 32'h33,        0);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk_i);
         rst_i = vecs[i].rst;
         drive_req(vecs[i].req, vecs[i].add, vecs[i].id, vecs[i].wen);
         m_gnt_i = vecs[i].gnt; m_r_valid_i = vecs[i].rv;
         m_r_opc_i = vecs[i].opc; m_r_rdata_i = vecs[i].rdata;
         #1;
         check($sformatf("row%0d s_gnt", i), 64'(s_gnt_o), 64'(vecs[i].e_gnt));
         check($sformatf("row%0d m_req", i), 64'(m_req_o), 64'(vecs[i].e_mreq));
         if (vecs[i].e_mreq) begin
            exp_madd = vecs[i].e_madd;
            check($sformatf("row%0d m_add", i), 64'(m_add_o), 64'(exp_madd));
            check($sformatf("row%0d m_wen", i), 64'(m_wen_o), 64'(vecs[i].e_mwen));
            check($sformatf("row%0d m_wdata", i), 64'(m_wdata_o), 64'(exp_madd ^ 32'h5A5A_5A5A));
            check($sformatf("row%0d m_be", i), 64'(m_be_o), 64'(exp_madd[5:2]));
         end
         check($sformatf("row%0d s_r_valid", i), 64'(s_r_valid_o), 64'(vecs[i].e_rv));
         check($sformatf("row%0d s_r_id", i), 64'(s_r_id_o), 64'(vecs[i].e_rid));
         check($sformatf("row%0d s_r_opc", i), 64'(s_r_opc_o), 64'(vecs[i].e_ropc));
         check($sformatf("row%0d s_r_rdata", i), 64'(s_r_rdata_o), 64'(vecs[i].e_rdata));
         check($sformatf("row%0d err", i), 64'(err_o), 64'(vecs[i].e_err));
      end

      // Ordering: four writes, random peripheral stalls, responses 1-3 cycles after grant.
      begin
         int sent = 0, got = 0, rsp_sent = 0, last_due = -1, due;
         ord_ids[0] = 9'h001; ord_ids[1] = 9'h002; ord_ids[2] = 9'h100; ord_ids[3] = 9'h080;
         for (int cyc = 0; cyc < 300 && got < 4; cyc++) begin
            @(negedge clk_i);
            if (sent < 4) drive_req(1'b1, 32'h3000_0000 + 32'(sent * 4), ord_ids[sent], 1'b0);
            else          drive_req(1'b0, '0, '0, 1'b0);
            m_gnt_i = 1'($urandom_range(0, 1));
            m_r_valid_i = 1'b0; m_r_opc_i = 1'b0; m_r_rdata_i = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
               void'(due_q.pop_front());
               m_r_valid_i = 1'b1;
               m_r_rdata_i = 32'hA000_0000 + 32'(rsp_sent);
               rsp_sent++;
            end
            #1;
            if (s_req_i && s_gnt_o) begin
               exp_q.push_back(ord_ids[sent]);
               sent++;
            end
            if (m_req_o && m_gnt_i) begin
               due = cyc + $urandom_range(1, 3);
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               due_q.push_back(due);
            end
            if (s_r_valid_o) begin
               if (exp_q.size() == 0) begin
                  check("ord unexpected s_r_valid", 64'(s_r_valid_o), 64'd0);
               end else begin
                  check($sformatf("ord%0d s_r_id", got), 64'(s_r_id_o), 64'(exp_q.pop_front()));
                  check($sformatf("ord%0d s_r_rdata", got), 64'(s_r_rdata_o), 64'(32'hA000_0000 + 32'(got)));
               end
               got++;
            end
         end
         check("ord responses received", 64'(got), 64'd4);
      end

      // Spurious response: only legal if out_cnt returned to 0.
      @(negedge clk_i);
      drive_req(1'b0, '0, '0, 1'b0);
      m_gnt_i = 1'b0; m_r_valid_i = 1'b1; m_r_rdata_i = 32'h5555_5555;
      #1 check("spur s_gnt", 64'(s_gnt_o), 64'd1);
      @(negedge clk_i);
      m_r_valid_i = 1'b0; m_r_rdata_i = '0;
      #1;
      check("spur err pulse", 64'(err_o), 64'd1);
      check("spur no s_r_valid", 64'(s_r_valid_o), 64'd0);
      check("spur s_r_id held", 64'(s_r_id_o), 64'h080);
      @(negedge clk_i);
      #1 check("spur err one cycle", 64'(err_o), 64'd0);

      // Reset with two transactions outstanding.
      @(negedge clk_i);
      drive_req(1'b1, 32'h4000_0000, 9'h0AA, 1'b1);
      #1 check("rst pre gnt0", 64'(s_gnt_o), 64'd1);
      @(negedge clk_i);
      drive_req(1'b1, 32'h4000_0004, 9'h0BB, 1'b1);
      #1 check("rst pre gnt1", 64'(s_gnt_o), 64'd1);
      @(negedge clk_i);
      drive_req(1'b0, '0, '0, 1'b0);
      rst_i = 1'b1;
      #1;
      check("rst s_gnt during", 64'(s_gnt_o), 64'd0);
      check("rst m_req during", 64'(m_req_o), 64'd0);
      check("rst m_add during", 64'(m_add_o), 64'd0);
      check("rst s_r_id during", 64'(s_r_id_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst s_gnt after", 64'(s_gnt_o), 64'd1);
      check("rst m_req after", 64'(m_req_o), 64'd0);
      check("rst s_r_valid after", 64'(s_r_valid_o), 64'd0);
      check("rst s_r_id after", 64'(s_r_id_o), 64'd0);
      check("rst s_r_rdata after", 64'(s_r_rdata_o), 64'd0);
      check("rst err after", 64'(err_o), 64'd0);
      @(negedge clk_i);
      m_r_valid_i = 1'b1; m_r_rdata_i = 32'h7777_7777;
      @(negedge clk_i);
      m_r_valid_i = 1'b0; m_r_rdata_i = '0;
      #1;
      check("stale err", 64'(err_o), 64'd1);
      check("stale no s_r_valid", 64'(s_r_valid_o), 64'd0);
      check("stale rdata untouched", 64'(s_r_rdata_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/periph_slave_buffer.md
Name: periph_slave_buffer

Overview:
- Sits directly downstream of one slave port of the cluster peripheral crossbar, between that port and one slow cluster peripheral.
- Decouples crossbar grant from peripheral grant with a small request FIFO.
- Tracks the requester ID of every outstanding transaction, because the peripheral does not carry IDs.
- Returns each response with its ID, in order, one cycle after the peripheral produces it.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ID_WIDTH, 9, requester ID width (cores + master peripherals).
- DEPTH, 2, maximum outstanding transactions; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_req_i  in  1  crossbar request
- s_add_i  in  ADDR_WIDTH  address
- s_wen_i  in  1  1=read, 0=write
- s_wdata_i  in  DATA_WIDTH  write data
- s_be_i  in  BE_WIDTH  byte enables
- s_id_i  in  ID_WIDTH  requester ID
- s_gnt_o  out  1  grant to crossbar
- s_r_valid_o  out  1  response valid
- s_r_id_o  out  ID_WIDTH  response ID
- s_r_opc_o  out  1  response opcode (0=OK, 1=error)
- s_r_rdata_o  out  DATA_WIDTH  read data
- m_req_o  out  1  peripheral request
- m_add_o  out  ADDR_WIDTH  address
- m_wen_o  out  1  read/write
- m_wdata_o  out  DATA_WIDTH  write data
- m_be_o  out  BE_WIDTH  byte enables
- m_gnt_i  in  1  peripheral grant
- m_r_valid_i  in  1  peripheral response valid (reads and writes)
- m_r_opc_i  in  1  peripheral response opcode
- m_r_rdata_i  in  DATA_WIDTH  peripheral read data
- err_o  out  1  one-cycle pulse: response received with nothing outstanding

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high. While rst_i=1, clear all FIFO pointers and the outstanding count, and drive every output to 0 (s_gnt_o=0 during reset).
- Outstanding count: out_cnt, range 0..DEPTH. +1 on a slave handshake (s_req_i & s_gnt_o); −1 on m_r_valid_i when out_cnt>0. Both in the same cycle leaves out_cnt unchanged.
- Slave grant: s_gnt_o = (out_cnt < DEPTH) & ~rst_i. Combinational and independent of s_req_i.
- On slave handshake:
  - Push {add, wen, wdata, be} into the request FIFO.
  - Push s_id_i into the ID FIFO.
  - Both FIFOs have DEPTH entries and never overflow, because out_cnt bounds them.
- Peripheral request path:
  - m_req_o = request FIFO not empty; payload is the FIFO head.
  - Pop on m_req_o & m_gnt_i.
  - First-word latency: a request accepted in cycle t appears on m_req_o in cycle t+1 at the earliest; there is no combinational s→m path.
  - Payload is held stable while m_req_o=1 and m_gnt_i=0.
  - Push and pop in the same cycle are allowed. Pointers wrap modulo DEPTH.
- Response path:
  - On m_r_valid_i with out_cnt>0, pop the ID FIFO.
  - In the next cycle: s_r_valid_o=1, s_r_id_o=popped ID, s_r_opc_o=m_r_opc_i, s_r_rdata_o=m_r_rdata_i (rdata registered for writes as well).
  - s_r_valid_o is a one-cycle pulse; the crossbar has no response backpressure.
  - Responses are strictly in order.
  - When s_r_valid_o=0, s_r_id_o, s_r_opc_o and s_r_rdata_o hold their last values.
- Spurious response: m_r_valid_i with out_cnt=0 is dropped, with no s_r_valid_o. err_o=1 in the next cycle.
- Reset mid-operation: in-flight transactions are discarded without responses. Late peripheral responses after reset hit the spurious case and raise err_o.
- The peripheral may respond in the same cycle as its grant or any later cycle. A full FIFO with m_gnt_i=0 indefinitely keeps s_gnt_o=0; there is no timeout.

Decomposition:
- Package periph_buf_pkg holds:
  - opcode constants PERIPH_OPC_OK=1'b0, PERIPH_OPC_ERR=1'b1;
  - function clog2_min1 for pointer widths.
- One sub-module, periph_buf_fifo: parameterised width and depth, sync active-high reset, push/pop/full/empty/head. Instantiated twice: payload FIFO and ID FIFO.
- The out_cnt counter and the response register are in the top level.

Test Plan:
- Single read, immediate grant: s_req_i=1, add=0x1000_0004, id=0x004, m_gnt_i tied 1, peripheral answers rdata=0xDEADBEEF one cycle after grant → m_req_o at t+1; s_r_valid_o at t+3 with id=0x004, rdata=0xDEADBEEF, opc=0.
- Backpressure fill: m_gnt_i=0, DEPTH=2, three back-to-back requests with ids 1,2,3 → first two granted; s_gnt_o=0 on the third until the first response; m_add_o holds request 1 stable.
- Ordering: four writes (ids 0x001, 0x002, 0x100, 0x080); peripheral grants with random stalls and responds 1–3 cycles later → four s_r_valid_o pulses with ids in that exact order, out_cnt returns to 0.
- Simultaneous events: out_cnt=2 with m_r_valid_i and new s_req_i in the same cycle → s_gnt_o=0 that cycle, 1 the next; out_cnt ends at 2; no FIFO overflow.
- Error and spurious: peripheral returns opc=1 → s_r_opc_o=1 with the correct id. m_r_valid_i with out_cnt=0 → no s_r_valid_o, err_o pulses one cycle.
- Reset mid-operation: rst_i=1 for one cycle with 2 outstanding → all outputs 0 next cycle and s_gnt_o=1 after release. Stale m_r_valid_i after reset → err_o=1 and s_r_valid_o stays 0.
